led_scan_driver: RTL and testbench

- Generates the serial drive signals for the single-colour LED matrix panel: row data `r1`, row address `a`, shift clock `sclk` and latch `lat`.
- Sits directly upstream of the board-level pin-mapping stage, which forwards these four signals to the panel connector.
- Reads pixels from a 1-bit framebuffer through a synchronous read port.
- Scans rows continuously while enabled: shift one row, latch it, display it for a hold time, advance the row.

---
 rtl/led_panel_pkg.sv | 20 ++
 rtl/led_clk_div.sv | 35 +++
 rtl/led_scan_driver.sv | 138 +++++++++++++
 tb/tb_led_scan_driver.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared types and sizing helpers for the LED matrix panel datapath
// (scan driver, framebuffer and their glue).
package led_panel_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } scan_state_t;

  localparam int DEFAULT_COLS = 32;
  localparam int DEFAULT_ROWS = 2;

  // Bit width needed to index n items; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_clk_div.sv
// Half-period phase counter for the panel shift clock: tick marks the last
// cycle of a half period, phase is low (0) or high (1) half of the bit.
module led_clk_div
  import led_panel_pkg::*;
#(
  parameter int CLK_DIV = 4,
  localparam int CW = width_of(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          tick,
  output logic          phase,
  output logic [CW-1:0] cnt
);

  assign tick = run && (cnt == CW'(CLK_DIV - 1));

  // Held at the start of a low phase whenever the scan is not shifting or latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// Row-scanning serial driver for a single-colour LED panel: shifts one row
// out of a 1-bit framebuffer, latches it, holds it, then moves to the next row.
module led_scan_driver
  import led_panel_pkg::*;
#(
  parameter int COLS    = DEFAULT_COLS,
  parameter int ROWS    = DEFAULT_ROWS,
  parameter int CLK_DIV = 4,
  parameter int HOLD    = 1024,
  localparam int AW     = width_of(COLS * ROWS),
  localparam int RW     = width_of(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [AW-1:0] fb_addr,
  input  logic          fb_data,
  output logic          r1,
  output logic [RW-1:0] a,
  output logic          sclk,
  output logic          lat,
  output logic          frame_done
);

  localparam int CW = width_of(COLS);
  localparam int HW = width_of(HOLD);
  localparam int DW = width_of(CLK_DIV);

  scan_state_t   state;
  logic [RW-1:0] row;
  logic [RW-1:0] row_next;
  logic [CW-1:0] col;
  logic [HW-1:0] hold_cnt;
  logic          div_run;
  logic          tick;
  logic          phase;
  logic [DW-1:0] div_cnt;
  logic          row_last;
  logic          col_last;
  logic          hold_last;

  assign div_run   = (state == S_SHIFT) || (state == S_LATCH);
  assign row_last  = (row == RW'(ROWS - 1));
  assign col_last  = (col == CW'(COLS - 1));
  assign hold_last = (hold_cnt == HW'(HOLD - 1));
  assign row_next  = row_last ? '0 : row + 1'b1;

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  led_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .run  (div_run),
    .tick (tick),
    .phase(phase),
    .cnt  (div_cnt)
  );

  // fb_addr is issued at the first cycle of each bit; the pixel comes back one
  // cycle later and is captured into r1 at the end of the second low cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      hold_cnt   <= '0;
      fb_addr    <= '0;
      r1         <= 1'b0;
      a          <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          sclk <= 1'b0;
          lat  <= 1'b0;
          if (enable) begin
            state   <= S_SHIFT;
            col     <= '0;
            fb_addr <= addr_of(row, '0);
          end
        end
        S_SHIFT: begin
          if (!phase && div_cnt == DW'(1)) begin
            r1 <= fb_data;
          end
          if (tick) begin
            if (!phase) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (col_last) begin
                state <= S_LATCH;
                col   <= '0;
                lat   <= 1'b1;
                a     <= row;
              end else begin
                col     <= col + 1'b1;
                fb_addr <= addr_of(row, col + 1'b1);
              end
            end
          end
        end
        S_LATCH: begin
          if (tick) begin
            state    <= S_HOLD;
            lat      <= 1'b0;
            hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (hold_last) begin
            hold_cnt   <= '0;
            row        <= row_next;
            frame_done <= row_last;
            if (enable) begin
              state   <= S_SHIFT;
              col     <= '0;
              fb_addr <= addr_of(row_next, '0);
            end else begin
              state <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver on a 4x2 panel with a small
// synchronous framebuffer model feeding fb_data.
module tb_led_scan_driver;

  localparam int COLS    = 4;
  localparam int ROWS    = 2;
  localparam int CLK_DIV = 2;
  localparam int HOLD    = 3;
  localparam int FRAME   = ROWS * (COLS * 2 * CLK_DIV + CLK_DIV + HOLD);

  typedef struct packed {
    logic       bit_v;
    logic [2:0] addr;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       fb_data = 1'b0;
  logic [2:0] fb_addr;
  logic       r1;
  logic [0:0] a;
  logic       sclk;
  logic       lat;
  logic       frame_done;

  logic [7:0] fb_mem = 8'b0110_1001;
  logic       x_mode = 1'b0;
  logic [2:0] addr_cur = 3'd0;
  logic [2:0] addr_prev = 3'd0;
  logic       addr_new = 1'b0;

  pix_t       pix_q[$];
  logic [0:0] a_q[$];
  int         checks = 0;
  int         errors = 0;

  led_scan_driver #(
    .COLS(COLS),
    .ROWS(ROWS),
    .CLK_DIV(CLK_DIV),
    .HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .r1(r1),
    .a(a),
    .sclk(sclk),
    .lat(lat),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read framebuffer; in x_mode data is valid only the cycle after a new address.
  always @(negedge clk) begin
    addr_new  = (fb_addr != addr_prev);
    addr_cur  = fb_addr;
    addr_prev = fb_addr;
  end

  always @(posedge clk) begin
    #1;
    fb_data = (x_mode && !addr_new) ? 1'bx : fb_mem[addr_cur];
  end

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    x_mode = 1'b0;
    pix_q.delete();
    a_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_row(input int r);
    pix_t p;
    for (int c = 0; c < COLS; c++) begin
      p.bit_v = fb_mem[r * COLS + c];
      p.addr  = 3'(r * COLS + c);
      pix_q.push_back(p);
    end
  endtask

  task automatic test_reset();
    logic prev;
    int   rises;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({r1, a, sclk, lat, frame_done, fb_addr} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b expected 00000000", {r1, a, sclk, lat, frame_done, fb_addr});
    end
    rst    = 1'b0;
    enable = 1'b1;
    rises  = 0;
    prev   = 1'b0;
    for (int c = 0; c < 30 && rises < 2; c++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    checks++;
    if (rises != 2) begin
      errors++;
      $display("[TB] FAIL reset_prep: got %0d sclk rises expected 2", rises);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({r1, a, sclk, lat, frame_done, fb_addr} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b expected 00000000", {r1, a, sclk, lat, frame_done, fb_addr});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({r1, a, sclk, lat, frame_done, fb_addr} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_held: got %b expected 00000000", {r1, a, sclk, lat, frame_done, fb_addr});
    end
    rst   = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int k = 1; k <= 12 && rises < 2; k++) begin
      @(negedge clk);
      if (sclk && !prev) begin
        rises++;
        checks++;
        if (rises == 1 && (k != 3 || r1 !== fb_mem[0] || fb_addr !== 3'd0)) begin
          errors++;
          $display("[TB] FAIL reset_restart: got cycle=%0d r1=%b addr=%0d expected cycle=3 r1=%b addr=0", k, r1, fb_addr, fb_mem[0]);
        end
        if (rises == 2 && (r1 !== fb_mem[1] || fb_addr !== 3'd1)) begin
          errors++;
          $display("[TB] FAIL reset_col1: got r1=%b addr=%0d expected r1=%b addr=1", r1, fb_addr, fb_mem[1]);
        end
      end
      prev = sclk;
    end
    checks++;
    if (rises != 2) begin
      errors++;
      $display("[TB] FAIL reset_restart_timeout: got %0d rises expected 2", rises);
    end
  endtask

  task automatic test_pixel_pattern();
    pix_t       p;
    logic [0:0] exp_a;
    logic       prev_s;
    logic       prev_l;
    int         lat_len;
    apply_reset();
    push_row(0);
    push_row(1);
    a_q.push_back(1'b0);
    a_q.push_back(1'b1);
    enable  = 1'b1;
    prev_s  = 1'b0;
    prev_l  = 1'b0;
    lat_len = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sclk && !prev_s && pix_q.size() > 0) begin
        p = pix_q.pop_front();
        checks++;
        if (r1 !== p.bit_v || fb_addr !== p.addr) begin
          errors++;
          $display("[TB] FAIL pix_shift: got r1=%b addr=%0d expected r1=%b addr=%0d", r1, fb_addr, p.bit_v, p.addr);
        end
      end
      if (lat && !prev_l && a_q.size() > 0) begin
        exp_a = a_q.pop_front();
        checks++;
        if (a !== exp_a) begin
          errors++;
          $display("[TB] FAIL latch_row: got a=%b expected a=%b", a, exp_a);
        end
      end
      if (lat) begin
        lat_len++;
      end else if (prev_l) begin
        checks++;
        if (lat_len != CLK_DIV) begin
          errors++;
          $display("[TB] FAIL lat_width: got %0d cycles expected %0d", lat_len, CLK_DIV);
        end
        lat_len = 0;
      end
      prev_s = sclk;
      prev_l = lat;
      if (pix_q.size() == 0 && a_q.size() == 0 && !lat) break;
    end
    checks++;
    if (pix_q.size() != 0 || a_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pattern_timeout: got %0d pixels %0d latches pending expected 0", pix_q.size(), a_q.size());
    end
  endtask

  task automatic test_enable_drop();
    pix_t       p;
    logic [0:0] exp_a;
    logic       prev_s;
    logic       prev_l;
    int         rises;
    int         lats;
    int         fds;
    apply_reset();
    enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    prev_s = 1'b0;
    prev_l = 1'b0;
    rises  = 0;
    lats   = 0;
    fds    = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sclk && !prev_s) rises++;
      if (lat && !prev_l) lats++;
      if (frame_done) fds++;
      prev_s = sclk;
      prev_l = lat;
    end
    checks++;
    if (rises != COLS || lats != 1 || fds != 0) begin
      errors++;
      $display("[TB] FAIL drop_completes_row: got rises=%0d lats=%0d frame_done=%0d expected %0d/1/0", rises, lats, fds, COLS);
    end
    checks++;
    if ({a, sclk, lat} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL drop_idle_outputs: got a=%b sclk=%b lat=%b expected 0/0/0", a, sclk, lat);
    end
    push_row(1);
    a_q.push_back(1'b1);
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sclk && !prev_s && pix_q.size() > 0) begin
        p = pix_q.pop_front();
        checks++;
        if (r1 !== p.bit_v || fb_addr !== p.addr) begin
          errors++;
          $display("[TB] FAIL resume_shift: got r1=%b addr=%0d expected r1=%b addr=%0d", r1, fb_addr, p.bit_v, p.addr);
        end
      end
      if (lat && !prev_l && a_q.size() > 0) begin
        exp_a = a_q.pop_front();
        checks++;
        if (a !== exp_a) begin
          errors++;
          $display("[TB] FAIL resume_latch: got a=%b expected a=%b", a, exp_a);
        end
      end
      prev_s = sclk;
      prev_l = lat;
      if (pix_q.size() == 0 && a_q.size() == 0) break;
    end
    checks++;
    if (pix_q.size() != 0 || a_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL resume_timeout: got %0d pixels %0d latches pending expected 0", pix_q.size(), a_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic       prev;
    int         rise_k;
    logic [2:0] addr_seen;
    apply_reset();
    enable    = 1'b1;
    prev      = 1'b0;
    rise_k    = -1;
    addr_seen = 3'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k > 21 && sclk && !prev && rise_k < 0) begin
        rise_k    = k;
        addr_seen = fb_addr;
      end
      prev = sclk;
      if (k == 3) enable = 1'b0;
      if (k == 21) enable = 1'b1;
    end
    checks++;
    if (rise_k != 24 || addr_seen !== 3'd4) begin
      errors++;
      $display("[TB] FAIL boundary_reenable: got rise cycle=%0d addr=%0d expected 24 addr=4", rise_k, addr_seen);
    end
  endtask

  task automatic test_x_data();
    pix_t p;
    logic prev_s;
    logic found;
    apply_reset();
    enable = 1'b1;
    found  = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      found = frame_done;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL xdata_first_frame: got no frame_done expected one within 60 cycles");
    end
    x_mode = 1'b1;
    push_row(0);
    push_row(1);
    prev_s = sclk;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sclk && !prev_s && pix_q.size() > 0) begin
        p = pix_q.pop_front();
        checks++;
        if (r1 !== p.bit_v || fb_addr !== p.addr) begin
          errors++;
          $display("[TB] FAIL xdata_shift: got r1=%b addr=%0d expected r1=%b addr=%0d", r1, fb_addr, p.bit_v, p.addr);
        end
      end
      prev_s = sclk;
      if (pix_q.size() == 0) break;
    end
    checks++;
    if (pix_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL xdata_timeout: got %0d pixels pending expected 0", pix_q.size());
    end
    x_mode = 1'b0;
  endtask

  task automatic test_protocol();
    logic       prev_s;
    logic       prev_l;
    logic [0:0] prev_a;
    int         viol;
    int         lat_len;
    int         lat_pulses;
    int         fds;
    int         hold_win;
    int         fd_exp;
    apply_reset();
    enable     = 1'b1;
    prev_s     = 1'b0;
    prev_l     = 1'b0;
    prev_a     = 1'b0;
    viol       = 0;
    lat_len    = 0;
    lat_pulses = 0;
    fds        = 0;
    hold_win   = 0;
    fd_exp     = 0;
    for (int k = 1; k <= FRAME * 10 + 1; k++) begin
      @(negedge clk);
      if (sclk && lat) viol++;
      if (sclk && prev_s && a !== prev_a) viol++;
      if (!lat && prev_l) begin
        if (lat_len != CLK_DIV) viol++;
        lat_len  = 0;
        hold_win = HOLD;
      end
      if (lat) lat_len++;
      if (lat && !prev_l) lat_pulses++;
      if (hold_win > 0) begin
        if (sclk) viol++;
        hold_win--;
      end
      if (frame_done) begin
        fds++;
        if (k != FRAME + 1 + fd_exp * FRAME) viol++;
        fd_exp++;
      end
      prev_s = sclk;
      prev_l = lat;
      prev_a = a;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("[TB] FAIL protocol: got %0d violations expected 0", viol);
    end
    checks++;
    if (lat_pulses != 10 * ROWS) begin
      errors++;
      $display("[TB] FAIL lat_count: got %0d pulses expected %0d", lat_pulses, 10 * ROWS);
    end
    checks++;
    if (fds != 10) begin
      errors++;
      $display("[TB] FAIL frame_done_count: got %0d pulses expected 10", fds);
    end
  endtask

  initial begin
    test_reset();
    test_pixel_pattern();
    test_enable_drop();
    test_back_to_back();
    test_x_data();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
